// File: rtl/mux_sched_pkg.sv
// mux_sched_pkg: shared defaults and state encoding for the round-robin mux scheduler
package mux_sched_pkg;
    localparam int N_DEF         = 8;
    localparam int DATA_W_DEF    = 1;
    localparam int MAX_BURST_DEF = 4;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-priority encoder returning the first requester at or after ptr
module rr_pick #(
    parameter int N     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);
    logic [SEL_W-1:0] k;
    // scan farthest offset first so the nearest requester to ptr wins
    always_comb begin
        idx   = ptr;
        found = 1'b0;
        k     = ptr;
        for (int i = N - 1; i >= 0; i--) begin
            k = ptr + SEL_W'(i);
            if (req[k]) begin
                idx   = k;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler: round-robin burst scheduler sharing one N:1 selector among N requesters
module mux_rr_scheduler import mux_sched_pkg::*; #(
    parameter int N         = N_DEF,
    parameter int SEL_W     = $clog2(N),
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic [N*DATA_W-1:0] in_data,
    output logic [N-1:0]        in_ack,
    output logic [N-1:0]        gnt,
    output logic [SEL_W-1:0]    sel,
    output logic                busy,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    input  logic                out_ready
);
    state_t           state, state_d;
    logic [SEL_W-1:0] ptr, gnt_idx, pick_idx;
    logic [CNT_W-1:0] beat_cnt;
    logic             pick_found, xfer, last, rel;

    rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
        .req  (req),
        .ptr  (ptr),
        .idx  (pick_idx),
        .found(pick_found)
    );

    // sel tracks gnt_idx, so it holds its last value through the idle bubble
    assign busy      = state == BUSY;
    assign sel       = gnt_idx;
    assign out_valid = busy & req[gnt_idx];
    assign out_data  = in_data[gnt_idx*DATA_W +: DATA_W];
    assign xfer      = out_valid & out_ready;
    assign last      = beat_cnt == CNT_W'(MAX_BURST - 1);
    assign rel       = busy & (~req[gnt_idx] | (xfer & last));

    always_comb begin
        gnt          = '0;
        gnt[gnt_idx] = busy;
        in_ack       = xfer ? gnt : '0;
    end

    always_comb begin
        state_d = busy ? (rel ? IDLE : BUSY) : (pick_found ? BUSY : IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            gnt_idx  <= '0;
            beat_cnt <= '0;
        end else if (!busy) begin
            if (pick_found) begin
                gnt_idx  <= pick_idx;
                beat_cnt <= '0;
            end
        end else begin
            if (xfer) beat_cnt <= beat_cnt + 1'b1;
            if (rel)  ptr      <= gnt_idx + 1'b1;
        end
    end
endmodule
